// File: rtl/result_drain_ctrl.sv
// Result SRAM drain: walks rows 0..MATRIX_SIZE-1 into a 2-entry skid FIFO and a valid/ready port.
// Optional macro DRAIN_RELU_EN clamps negative lanes to zero at FIFO write.
module result_drain_ctrl #(
    parameter int ADDRESSSIZE     = 10,
    parameter int MATRIX_SIZE     = 32,
    parameter int PARTIAL_SUM_BW  = 24,
    parameter int WORDSIZE_Result = MATRIX_SIZE * PARTIAL_SUM_BW
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    output logic [ADDRESSSIZE-1:0]     sram_result_address,
    output logic                       sram_result_rd_en,
    input  logic [WORDSIZE_Result-1:0] sram_result_data_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORDSIZE_Result-1:0] out_data,
    output logic [ADDRESSSIZE-1:0]     out_row,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam logic [ADDRESSSIZE-1:0] LAST_ROW = ADDRESSSIZE'(MATRIX_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDRESSSIZE-1:0]     addr_q, addr_d;
    logic                       start_d_q;
    logic                       infl_q;
    logic [ADDRESSSIZE-1:0]     infl_addr_q;
    logic [WORDSIZE_Result-1:0] mem_data_q [2];
    logic [ADDRESSSIZE-1:0]     mem_row_q  [2];
    logic                       wr_ptr_q, rd_ptr_q;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       pop, push, issue;
    logic [2:0]                 occ;
    logic [WORDSIZE_Result-1:0] wr_data;

    function automatic logic [WORDSIZE_Result-1:0] lane_fix(
        input logic [WORDSIZE_Result-1:0] w
    );
        logic [WORDSIZE_Result-1:0] r;
        r = w;
`ifdef DRAIN_RELU_EN
        for (int l = 0; l < MATRIX_SIZE; l++) begin
            if (w[l*PARTIAL_SUM_BW + PARTIAL_SUM_BW - 1]) begin
                r[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = '0;
            end
        end
`endif
        return r;
    endfunction

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_row   = mem_row_q[rd_ptr_q];
    assign out_last  = out_valid && (out_row == LAST_ROW);
    assign busy      = (state_q == S_READ) || (state_q == S_FLUSH);
    assign done      = (state_q == S_DONE);

    assign pop     = out_valid && out_ready;
    assign push    = infl_q;
    assign wr_data = lane_fix(sram_result_data_out);
    assign cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};

    // Occupancy after this cycle's pop; a head leaving frees a slot for a new read.
    assign occ   = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    assign issue = (state_q == S_READ) && (occ < 3'd2);

    assign sram_result_address = addr_q;
    assign sram_result_rd_en   = issue;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !start_d_q) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (issue) begin
                    if (addr_q == LAST_ROW) begin
                        state_d = S_FLUSH;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if ((cnt_q == 2'd0) && !infl_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            start_d_q   <= 1'b0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            start_d_q   <= start;
            infl_q      <= issue;
            infl_addr_q <= addr_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                mem_data_q[i] <= '0;
                mem_row_q[i]  <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= wr_data;
                mem_row_q[wr_ptr_q]  <= infl_addr_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule
